sumador: RTL and testbench
==========================

// Module: sumador
// PURPOSE
//  Registered two's-complement adder for the fixed-point datapath.
//  - Adds the multiplier product (Multiplica) to an external accumulation term (Sum_ext).
//  - Used in multiply-accumulate chains; one result per clock.
//  - Result bit pattern (SATURATE=0) equals (Sum_ext + Multiplica) mod 2^(2N).
//  - Adds a valid qualifier and an overflow flag.
// PARAMETERS
//  N         24  half data width; all data ports are 2N bits (48 by default)
//  SATURATE  0   0: wrap-around result; 1: clamp to signed max/min on overflow
// PORTS
//  clk         in   1    system clock, rising-edge active
//  rst_n       in   1    asynchronous reset, active low
//  in_valid    in   1    operands valid this cycle
//  Sum_ext     in   2N   addend A, signed two's complement
//  Multiplica  in   2N   addend B (product), signed two's complement
//  Suma_G      out  2N   registered sum
//  out_valid   out  1    Suma_G / overflow valid
//  overflow    out  1    signed overflow occurred on the registered sample
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  - Reset (rst_n=0, asynchronous):
//    - Suma_G=0, out_valid=0, overflow=0 immediately.
//    - Outputs hold these values while rst_n stays low.
//    - Release is synchronous to the next clk edge.
//  - Latency exactly 1 cycle:
//    - in_valid=1 at edge k -> out_valid=1 after edge k, with the corresponding result.
//  - in_valid=0 at an edge:
//    - out_valid<=0.
//    - Suma_G and overflow hold their previous values (no toggling).
//  - No back-pressure: the block accepts a new operand pair every cycle.
//  - Arithmetic:
//    - raw = Sum_ext + Multiplica, computed at 2N+1 bits with sign extension.
//    - overflow = (Sum_ext[2N-1]==Multiplica[2N-1]) && (raw[2N-1]!=Sum_ext[2N-1]).
//    - SATURATE=0: Suma_G = raw[2N-1:0] (wrap); overflow still reported.
//    - SATURATE=1, no overflow: Suma_G = raw[2N-1:0].
//    - SATURATE=1, positive overflow: Suma_G = 0 followed by 2N-1 ones.
//    - SATURATE=1, negative overflow: Suma_G = 1 followed by 2N-1 zeros.
//  - Unsigned view: carry-out is discarded.
//    - Result matches unsigned (A+B) mod 2^(2N) when SATURATE=0.
//  - Reset mid-stream: any in-flight sample is lost; out_valid stays 0 until a new in_valid.
//  - X on operands while in_valid=0 must not propagate to outputs.
// TESTING
//  - Reset: drive rst_n=0 mid-cycle with in_valid=1.
//    -> Suma_G=0, out_valid=0, overflow=0 immediately, without waiting for clk.
//  - Basic add: A=0x000000000005, B=0x000000000003, in_valid=1.
//    -> next cycle Suma_G=0x000000000008, out_valid=1, overflow=0.
//  - Signed: A=0xFFFFFFFFFFFF (-1), B=0x000000000001.
//    -> Suma_G=0x000000000000, overflow=0.
//  - Overflow, SATURATE=0: A=B=0x7FFFFFFFFFFF.
//    -> Suma_G=0xFFFFFFFFFFFE, overflow=1.
//  - Overflow, SATURATE=1: A=B=0x7FFFFFFFFFFF -> Suma_G=0x7FFFFFFFFFFF, overflow=1.
//    - A=B=0x800000000000 -> Suma_G=0x800000000000, overflow=1.
//  - Regression: 5000 random pairs loaded from Bin1.txt (B) and Bin2.txt (A), back-to-back.
//    - Each Suma_G, 1 cycle later, must equal (A+B) mod 2^48.
//    - Log each result in binary to suma.txt.
//  - Hold: in_valid low for 3 cycles after a result.
//    -> out_valid=0 and Suma_G unchanged on all 3 cycles.

Source files
------------

// File: rtl/sumador.sv
// Registered two's-complement adder with valid qualifier and signed overflow flag.
// Optional saturation clamps the result to the signed extremes on overflow.
module sumador #(
  parameter int N        = 24,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*N-1:0] Sum_ext,
  input  logic [2*N-1:0] Multiplica,
  output logic [2*N-1:0] Suma_G,
  output logic           out_valid,
  output logic           overflow
);
  localparam int W = 2 * N;

  logic [W:0]   raw;
  logic         ovf;
  logic [W-1:0] sat_val;
  logic [W-1:0] res;

  logic [W-1:0] suma_g_d, suma_g_q;
  logic         out_valid_d, out_valid_q;
  logic         overflow_d, overflow_q;

  always_comb begin
    raw = {Sum_ext[W-1], Sum_ext} + {Multiplica[W-1], Multiplica};
    ovf = (Sum_ext[W-1] == Multiplica[W-1]) && (raw[W-1] != Sum_ext[W-1]);
    // raw[W] is the true sign of the sum, so it picks the clamp direction
    sat_val = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    res     = (SATURATE && ovf) ? sat_val : raw[W-1:0];
  end

  // Result and flag only load on a valid sample, so idle operands never reach the outputs
  always_comb begin
    suma_g_d    = suma_g_q;
    overflow_d  = overflow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      suma_g_d   = res;
      overflow_d = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suma_g_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      suma_g_q    <= suma_g_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Suma_G    = suma_g_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_sumador.sv
// Bench for sumador: wrap and saturating instances side by side, expectations
// from a wide signed reference model queued at drive time and popped after each edge.
module tb_sumador;
  localparam int W = 48;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] s_wrap;
    logic [W-1:0] s_sat;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sw, ss;
  logic         vw, vs, ow, os;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t m = '0;

  always #5 clk = ~clk;

  sumador #(.N(24), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Sum_ext(a), .Multiplica(b),
    .Suma_G(sw), .out_valid(vw), .overflow(ow));

  sumador #(.N(24), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Sum_ext(a), .Multiplica(b),
    .Suma_G(ss), .out_valid(vs), .overflow(os));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".vld_w"}, W'(vw), W'(e.vld));
    chk({tag, ".vld_s"}, W'(vs), W'(e.vld));
    chk({tag, ".sum_w"}, sw, e.s_wrap);
    chk({tag, ".sum_s"}, ss, e.s_sat);
    chk({tag, ".ovf_w"}, W'(ow), W'(e.ovf));
    chk({tag, ".ovf_s"}, W'(os), W'(e.ovf));
  endtask

  // Reference: exact signed sum at W+1 bits, compared against the W-bit signed range
  function automatic exp_t model(input exp_t prev, input logic v,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W:0] full;
    logic signed [W:0] maxv;
    logic signed [W:0] minv;
    exp_t e;
    e = prev;
    e.vld = v;
    if (v) begin
      maxv = (W+1)'(49'sh0_7FFF_FFFF_FFFF);
      minv = -(W+1)'(49'sh0_8000_0000_0000);
      full = $signed({x[W-1], x}) + $signed({y[W-1], y});
      e.ovf    = (full > maxv) || (full < minv);
      e.s_wrap = full[W-1:0];
      e.s_sat  = (full > maxv) ? maxv[W-1:0] : (full < minv) ? minv[W-1:0] : full[W-1:0];
    end
    return e;
  endfunction

  // Called 1 time unit after a rising edge; drives, queues expectation, checks after next edge
  task automatic step(input string tag, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    in_valid = v;
    a = x;
    b = y;
    m = model(m, v, x, y);
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    exp_t zero;
    logic [W-1:0] ra, rb, hold_w, hold_s;
    zero = '0;

    // Power-on reset with a clean falling edge
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_all("por", zero);
    rst_n = 1'b1;

    // Directed cases
    step("basic",  1'b1, 48'h000000000005, 48'h000000000003);
    step("signed", 1'b1, 48'hFFFFFFFFFFFF, 48'h000000000001);
    step("posovf", 1'b1, 48'h7FFFFFFFFFFF, 48'h7FFFFFFFFFFF);
    step("negovf", 1'b1, 48'h800000000000, 48'h800000000000);
    step("mixsgn", 1'b1, 48'h7FFFFFFFFFFF, 48'h800000000000);
    step("edgpos", 1'b1, 48'h7FFFFFFFFFFE, 48'h000000000001);
    step("edgneg", 1'b1, 48'h800000000001, 48'hFFFFFFFFFFFF);
    step("negovf1", 1'b1, 48'h800000000000, 48'hFFFFFFFFFFFF);

    // Hold: three idle cycles, outputs frozen, idle operands ignored
    step("pre_hold", 1'b1, 48'h123456789ABC, 48'h000011112222);
    hold_w = sw;
    hold_s = ss;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, W'($urandom()) ^ {$urandom(), 16'h0}, 'x);
      chk("hold_w_const", sw, hold_w);
      chk("hold_s_const", ss, hold_s);
    end

    // Back-to-back random regression, biased toward the sign extremes every few samples
    for (int i = 0; i < 300; i++) begin
      ra = {$urandom(), $urandom()} >> 16;
      rb = {$urandom(), $urandom()} >> 16;
      if (i % 4 == 1) begin
        ra[W-1:W-3] = 3'b011;
        rb[W-1:W-3] = 3'b011;
      end else if (i % 4 == 3) begin
        ra[W-1:W-3] = 3'b100;
        rb[W-1:W-3] = 3'b101;
      end
      step("rand", 1'b1, ra, rb);
    end

    // Reset mid-cycle with a valid sample in flight
    step("pre_rst", 1'b1, 48'h000000000010, 48'h000000000020);
    in_valid = 1'b1;
    a = 48'h7FFFFFFFFFFF;
    b = 48'h7FFFFFFFFFFF;
    #3 rst_n = 1'b0;
    #1 chk_all("rst_async", zero);
    @(posedge clk); #1;
    chk_all("rst_hold", zero);
    rst_n = 1'b1;
    m = '0;
    q.delete();
    step("post_rst_idle", 1'b0, 48'h000000000001, 48'h000000000001);
    step("post_rst_go",   1'b1, 48'h000000000002, 48'h000000000003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
